// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencer: generates N terms into a single-port SRAM, then reads
// them back and streams them over a valid/ready handshake.
module fib_seq_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] n_terms,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic                  mem_we,
   output logic                  mem_oe,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_GEN  = 3'd1;
   localparam logic [2:0] S_RD   = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] last;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;

   logic [DATA_WIDTH:0]   sum;
   logic [ADDR_WIDTH:0]   addr_p2;
   logic                  at_last;

   // The carry bit of the widened sum marks a term that wrapped; addr+2 is the
   // index of that term and is kept one bit wider so it cannot alias.
   assign sum     = {1'b0, a} + {1'b0, b};
   assign addr_p2 = {1'b0, addr} + (ADDR_WIDTH + 1)'(2);
   assign at_last = (addr == last);

   // NOTE: all state lives in one async-reset block using non-blocking
   // assignments, so every register samples pre-edge values consistently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         last     <= '0;
         addr     <= '0;
         a        <= '0;
         b        <= '0;
         out_data <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  last     <= n_terms;
                  addr     <= '0;
                  a        <= '0;
                  b        <= DATA_WIDTH'(1);
                  overflow <= 1'b0;
                  state    <= S_GEN;
               end
            end
            S_GEN: begin
               a <= b;
               b <= sum[DATA_WIDTH-1:0];
               if (sum[DATA_WIDTH] && (addr_p2 <= {1'b0, last}))
                  overflow <= 1'b1;
               if (at_last) begin
                  addr  <= '0;
                  state <= S_RD;
               end else begin
                  addr <= addr + ADDR_WIDTH'(1);
               end
            end
            S_RD: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               out_data <= mem_rdata;
               state    <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  if (at_last) begin
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     addr  <= addr + ADDR_WIDTH'(1);
                     state <= S_RD;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Strobes depend on state only, so they are glitch-free w.r.t. inputs.
   assign busy      = (state != S_IDLE);
   assign mem_we    = (state == S_GEN);
   assign mem_oe    = (state == S_RD);
   assign out_valid = (state == S_OUT);
   assign mem_addr  = addr;
   assign mem_wdata = mem_we ? a : '0;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl: SRAM model, Fibonacci reference model,
// randomized backpressure and start pokes.
module tb_fib_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] n_terms;
   logic       busy, done, overflow;
   logic       mem_we, mem_oe;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;

   int compared   = 0;
   int mismatched = 0;
   int collisions = 0;

   logic [7:0] sram [16];
   int         wr_addr_q[$];
   int         wr_data_q[$];

   fib_seq_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .n_terms   (n_terms),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .mem_we    (mem_we),
      .mem_oe    (mem_oe),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // Registered-read SRAM plus a write/collision monitor.
   always @(posedge clk) begin
      if (mem_we) begin
         sram[mem_addr] <= mem_wdata;
         wr_addr_q.push_back(int'(mem_addr));
         wr_data_q.push_back(int'(mem_wdata));
      end
      if (mem_oe) mem_rdata <= sram[mem_addr];
      if (mem_we && mem_oe) collisions <= collisions + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int fib(input int k);
      int x = 0;
      int y = 1;
      int t;
      for (int i = 0; i < k; i++) begin
         t = x + y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_ovf"}, overflow, 0);
      check({tag, "_we"}, mem_we, 0);
      check({tag, "_oe"}, mem_oe, 0);
      check({tag, "_addr"}, mem_addr, 0);
      check({tag, "_wdata"}, mem_wdata, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_data"}, out_data, 0);
   endtask

   // One full run; starts at the current sample point (may be a done cycle).
   task automatic run(input int n, input bit rnd_ready, input bit poke);
      int         exp_q[$];
      int         got_q[$];
      bit         exp_ovf = 1'b0;
      int         cyc;
      int         first_valid = -1;
      int         early_done = 0;
      bit         fin = 1'b0;
      bit         hs, stall;
      logic [7:0] held;

      for (int k = 0; k <= n; k++) begin
         exp_q.push_back(fib(k) % 256);
         if (fib(k) >= 256) exp_ovf = 1'b1;
      end
      wr_addr_q.delete();
      wr_data_q.delete();

      start   = 1'b1;
      n_terms = 4'(n);
      tick();
      start   = 1'b0;
      n_terms = 4'($urandom);
      check("busy_after_start", busy, 1);
      check("done_low_after_start", done, 0);

      cyc = 1;
      while (!fin && cyc < 600) begin
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (done) early_done++;
         if (poke && busy) begin
            start   = 1'($urandom_range(0, 1));
            n_terms = 4'($urandom);
         end
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         hs    = out_valid && out_ready;
         stall = out_valid && !out_ready;
         held  = out_data;
         if (hs) got_q.push_back(int'(out_data));
         tick();
         cyc++;
         start = 1'b0;
         if (stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, held);
            check("stall_sram_idle", mem_we | mem_oe, 0);
         end
         if (hs && got_q.size() == exp_q.size()) fin = 1'b1;
      end

      if (!fin) begin
         check("timeout", 0, 1);
      end else begin
         check("done_pulse", done, 1);
         check("idle_in_done", busy, 0);
      end
      check("no_early_done", early_done, 0);
      check("first_valid_cycle", first_valid, n + 4);
      check("out_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("term%0d", i), got_q[i], exp_q[i]);
      check("overflow", overflow, exp_ovf);
      check("write_count", wr_addr_q.size(), n + 1);
      for (int i = 0; i < wr_addr_q.size() && i <= n; i++) begin
         check($sformatf("wr_addr%0d", i), wr_addr_q[i], i);
         check($sformatf("wr_data%0d", i), wr_data_q[i], exp_q[i]);
      end
      check("we_oe_exclusive", collisions, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      n_terms   = '0;
      out_ready = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();
      check("idle_busy", busy, 0);

      // Basic, overflow boundary, clear-on-start, full depth
      run(7, 1'b0, 1'b0);
      tick();
      check("done_one_cycle", done, 0);
      run(13, 1'b0, 1'b0);
      run(14, 1'b0, 1'b0);
      check("ovf_set_n14", overflow, 1);
      run(3, 1'b0, 1'b0);
      check("ovf_cleared", overflow, 0);
      run(15, 1'b0, 1'b0);

      // Backpressure, single term, ignored starts
      run(5, 1'b1, 1'b0);
      run(0, 1'b0, 1'b0);
      run(0, 1'b1, 1'b0);
      run(6, 1'b1, 1'b1);
      run(15, 1'b0, 1'b1);

      // Asynchronous reset mid-GEN, then a normal run
      start   = 1'b1;
      n_terms = 4'd10;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("gen_active_before_reset", mem_we, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrun_reset");
      tick();
      rst_n = 1'b1;
      tick();
      run(4, 1'b0, 1'b0);

      // Randomized runs
      repeat (4) run($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fib_seq_ctrl.md
# fib_seq_ctrl

Sequencer that drives the 16×8 single-port SRAM of the Fibonacci datapath. On `start` it computes the first N Fibonacci terms modulo 2^DATA_WIDTH and writes them to consecutive SRAM addresses. It then reads them back in address order and streams them to the downstream consumer over a valid/ready handshake. It owns every SRAM control pin: `mem_we`, `mem_oe`, `mem_addr` and `mem_wdata`.

## Interface
- ADDR_WIDTH, 4, SRAM address width; the sequence holds up to 2^ADDR_WIDTH terms.
- DATA_WIDTH, 8, term width; arithmetic is modulo 2^DATA_WIDTH.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a run; sampled only in IDLE.
- n_terms  in  ADDR_WIDTH  index of the last term; the run produces n_terms+1 terms. Captured when start is accepted.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse after the final output handshake.
- overflow  out  1  sticky flag: some written term wrapped modulo 2^DATA_WIDTH. Cleared on accepted start.
- mem_we  out  1  SRAM write enable.
- mem_oe  out  1  SRAM output enable.
- mem_addr  out  ADDR_WIDTH  SRAM address.
- mem_wdata  out  DATA_WIDTH  SRAM write data.
- mem_rdata  in  DATA_WIDTH  SRAM read data; registered by the SRAM, valid the cycle after mem_oe.
- out_valid  out  1  out_data holds a term.
- out_data  out  DATA_WIDTH  streamed term.
- out_ready  in  1  consumer accepts out_data.

## Operation
- Registers:
  - state
  - last (ADDR_WIDTH)
  - addr (ADDR_WIDTH)
  - a, b (DATA_WIDTH)
  - out_data, done, overflow
- Reset: state=IDLE; addr, last, a, b, out_data all 0; done=0; overflow=0. Every output is therefore 0.
- IDLE:
  - On start=1: last←n_terms, addr←0, a←0, b←1, overflow←0; go to GEN.
- GEN (mem_we=1, mem_wdata=a, mem_addr=addr):
  - Writes term F(addr) each cycle.
  - a←b; b←(a+b) truncated to DATA_WIDTH.
  - If the sum carries out and addr+2 ≤ last, set overflow. This makes overflow mean exactly that a written term wrapped.
  - If addr==last: addr←0, go to RD. Otherwise addr←addr+1.
- RD (mem_oe=1, mem_addr=addr): go to WAIT.
- WAIT: out_data←mem_rdata; go to OUT.
- OUT (out_valid=1):
  - Hold out_data stable until out_ready=1.
  - On handshake with addr==last: done←1, go to IDLE.
  - On handshake otherwise: addr←addr+1, go to RD.
- mem_we, mem_oe and out_valid are decoded from the state register only; they never depend on inputs in the same cycle.
- mem_we and mem_oe are never high together. Both are 0 in IDLE, WAIT and OUT.
- start while busy is ignored. n_terms changes after acceptance have no effect.
- n_terms=0 produces a single term (0): one GEN cycle and one output.
- n_terms=2^ADDR_WIDTH−1 fills the whole SRAM. addr must not wrap before the last==addr compare.
- Asynchronous reset mid-run aborts immediately. SRAM contents are don't-care, and the next start regenerates the sequence from scratch.

## Timing
- Start accepted at edge T0:
  - GEN occupies cycles T1 … T(last+1).
  - RD is at T(last+2) and WAIT at T(last+3).
  - First out_valid is at T(last+4).
- With out_ready held high: one term every 3 cycles (RD, WAIT, OUT).
- done is high for exactly one cycle: the cycle after the last handshake edge, with state already IDLE and busy=0.
- A start in the done cycle is accepted.
- out_ready low stalls in OUT indefinitely. out_valid and out_data hold, and the SRAM stays idle.
- The overflow value is final once GEN exits and holds until the next accepted start.

## Test plan
- Reset: assert rst_n=0 mid-GEN → all outputs 0 the same cycle and state IDLE; after release, start works normally.
- Basic: n_terms=7, out_ready=1 → stream 0,1,1,2,3,5,8,13; done pulse once; overflow=0; first out_valid 11 cycles after the start edge.
- Overflow boundary:
  - n_terms=13 → stream ends …144,233 with overflow=0.
  - n_terms=14 → last term 121 (377 mod 256) with overflow=1.
  - A following start clears overflow.
- Full depth: n_terms=15 → 16 writes to addresses 0..15, last two outputs 121 and 98, no address wrap.
- Backpressure: random out_ready, n_terms=5 → out_data is stable while out_valid && !out_ready; order 0,1,1,2,3,5 with no duplicates or drops.
- Edge cases:
  - n_terms=0 → single output 0.
  - start pulsed during GEN/OUT → ignored.
  - Check mem_we and mem_oe are never high together.
